// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        D_ADDR,
        D_DATA,
        I_ADDR,
        I_DATA
    } arb_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// SRAM-like memory bus: address phase (req/addr_ok) followed by a data phase (data_ok).
interface mem_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          bus_req;
    logic          bus_wr;
    logic [1:0]    bus_size;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_addr_ok;
    logic          bus_data_ok;
    logic [DW-1:0] bus_rdata;

    modport master (
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/arb_hold_reg.sv
// Completion flag plus held read data for one requester; result survives
// until the pipeline advances, and a flush always clears the flag.
module arb_hold_reg #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          resp,
    input  logic          discard,
    input  logic          flush,
    input  logic          longest_stall,
    input  logic [DW-1:0] rdata_in,
    output logic          done,
    output logic [DW-1:0] rdata
);
    logic          done_q, done_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          set;

    assign set = resp && !discard;

    always_comb begin
        done_d  = done_q;
        rdata_d = rdata_q;
        // flush beats a same-cycle set; an unstalled edge does not
        if (flush) begin
            done_d = 1'b0;
        end else if (set) begin
            done_d = 1'b1;
        end else if (!longest_stall) begin
            done_d = 1'b0;
        end
        if (set) begin
            rdata_d = rdata_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    assign done  = done_q;
    assign rdata = rdata_q;
endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises instruction fetch and data access onto one memory port,
// data first, one transaction outstanding at a time.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inst_req,
    input  logic [AW-1:0]      inst_addr,
    output logic [DW-1:0]      inst_rdata,
    output logic               stall_from_if,
    input  logic               data_req,
    input  logic               data_wr,
    input  logic [1:0]         data_size,
    input  logic [AW-1:0]      data_addr,
    input  logic [DW-1:0]      data_wdata,
    output logic [DW-1:0]      data_rdata,
    output logic               stall_from_mem,
    input  logic               longest_stall,
    input  logic               flush_exceptM,
    mem_bus_arbiter_if.master  bus
);
    arb_state_e    state_q, state_d;
    logic          discard_q, discard_d;
    logic          wr_q, wr_d;
    logic [1:0]    size_q, size_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          inst_done, data_done;

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        wr_d      = wr_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        case (state_q)
            IDLE: begin
                if (!flush_exceptM) begin
                    if (data_req && !data_done) begin
                        state_d = D_ADDR;
                        wr_d    = data_wr;
                        size_d  = data_size;
                        addr_d  = data_addr;
                        wdata_d = data_wdata;
                    end else if (inst_req && !inst_done) begin
                        state_d = I_ADDR;
                        wr_d    = 1'b0;
                        size_d  = SIZE_WORD;
                        addr_d  = inst_addr;
                        wdata_d = '0;
                    end
                end
            end
            D_ADDR, I_ADDR: begin
                // once the address is accepted the response must be drained, even if flushed
                if (bus.bus_addr_ok) begin
                    state_d = (state_q == D_ADDR) ? D_DATA : I_DATA;
                    if (flush_exceptM) discard_d = 1'b1;
                end else if (flush_exceptM) begin
                    state_d = IDLE;
                end
            end
            D_DATA, I_DATA: begin
                if (bus.bus_data_ok) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                end else if (flush_exceptM) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
            wr_q      <= 1'b0;
            size_q    <= SIZE_BYTE;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            wr_q      <= wr_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign bus.bus_req   = (state_q == D_ADDR) || (state_q == I_ADDR);
    assign bus.bus_wr    = wr_q;
    assign bus.bus_size  = size_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;

    arb_hold_reg #(.DW(DW)) u_if_hold (
        .clk           (clk),
        .rst           (rst),
        .resp          (bus.bus_data_ok && (state_q == I_DATA)),
        .discard       (discard_q),
        .flush         (flush_exceptM),
        .longest_stall (longest_stall),
        .rdata_in      (bus.bus_rdata),
        .done          (inst_done),
        .rdata         (inst_rdata)
    );

    arb_hold_reg #(.DW(DW)) u_mem_hold (
        .clk           (clk),
        .rst           (rst),
        .resp          (bus.bus_data_ok && (state_q == D_DATA)),
        .discard       (discard_q),
        .flush         (flush_exceptM),
        .longest_stall (longest_stall),
        .rdata_in      (bus.bus_rdata),
        .done          (data_done),
        .rdata         (data_rdata)
    );

    assign stall_from_if  = inst_req && !inst_done;
    assign stall_from_mem = data_req && !data_done;
endmodule
